// File: rtl/sigmoid_pkg.sv
// Shared definitions for the sigmoid lookup-table write path: default widths,
// the S7.8 value of 1.0, and the loader FSM state encoding.
package sigmoid_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int FRAC_BITS_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 11;

    localparam logic [15:0] ONE_Q = 16'h0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sigmoid_entry_sat.sv
// Clamps one signed S7.8 table entry into [0, 1.0] and reports whether it had
// to be clipped. Purely combinational.
module sigmoid_entry_sat #(
    parameter int WIDTH     = sigmoid_pkg::WIDTH_DEF,
    parameter int FRAC_BITS = sigmoid_pkg::FRAC_BITS_DEF
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_clip
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        o_data = i_data;
        o_clip = 1'b0;
        if (i_data[WIDTH-1]) begin
            o_data = '0;
            o_clip = 1'b1;
        end else if ($signed(i_data) > $signed(ONE)) begin
            o_data = ONE;
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/sigmoid_lut_writer.sv
// Loads the sigmoid table RAM from a valid/ready entry stream in ascending
// address order, saturating entries and flagging range/monotonicity errors.
module sigmoid_lut_writer #(
    parameter int WIDTH      = sigmoid_pkg::WIDTH_DEF,
    parameter int FRAC_BITS  = sigmoid_pkg::FRAC_BITS_DEF,
    parameter int ADDR_WIDTH = sigmoid_pkg::ADDR_WIDTH_DEF,
    parameter bit CHECK_MONO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy,
    output logic                  lut_valid,
    output logic                  range_err,
    output logic                  mono_err
);

    import sigmoid_pkg::*;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_prev;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WIDTH-1:0]      r_wr_data;
    logic                  r_range_err;
    logic                  r_mono_err;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_restart;
    logic [WIDTH-1:0]      w_sat_data;
    logic                  w_clip;

    sigmoid_entry_sat #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .i_data (s_data),
        .o_data (w_sat_data),
        .o_clip (w_clip)
    );

    assign w_accept  = s_valid && (r_state == LOAD);
    assign w_last    = (r_addr == {ADDR_WIDTH{1'b1}});
    // A start during LOAD is ignored; only IDLE or DONE begin a fresh load.
    assign w_restart = start && (r_state != LOAD);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        busy         = 1'b0;
        lut_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept && w_last) w_next_state = DONE;
            end
            DONE: begin
                lut_valid = ~(r_range_err | r_mono_err);
                if (start) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_prev      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_range_err <= 1'b0;
            r_mono_err  <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_restart) begin
                r_addr      <= '0;
                r_prev      <= '0;
                r_range_err <= 1'b0;
                r_mono_err  <= 1'b0;
            end else if (w_accept) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_sat_data;
                r_addr    <= r_addr + ADDR_WIDTH'(1);
                r_prev    <= w_sat_data;
                if (w_clip) r_range_err <= 1'b1;
                // The predecessor check compares saturated values, which are never negative.
                if (CHECK_MONO && (w_sat_data < r_prev) && (r_addr != '0)) r_mono_err <= 1'b1;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign range_err = r_range_err;
    assign mono_err  = r_mono_err;

endmodule
